// File: rtl/uart_arb_pkg.sv
// Shared types for uart_tx_arbiter: FSM encoding, defaults, one-hot helper.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARB  = 3'd1,
        S_LOAD = 3'd2,
        S_WAIT = 3'd3,
        S_GAP  = 3'd4,
        S_HOLD = 3'd5
    } arb_state_t;

    localparam int DEFAULT_GAP_TIMEOUT = 1024;
    localparam int MAX_REQ = 8;

    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_rr_select.sv
// Combinational one-hot winner picker: round-robin from ptr, or lowest
// index when UART_ARB_FIXED_PRIORITY_EN is defined.
module uart_rr_select #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

`ifdef UART_ARB_FIXED_PRIORITY_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) grant = NUM_REQ'(1) << i;
        end
    end
`else
    int idx;

    // Walk the search order backwards so the earliest hit is written last.
    always_comb begin
        grant = '0;
        idx   = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (req[idx]) grant = NUM_REQ'(1) << idx;
        end
    end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular arbiter sharing one uart_tx between NUM_REQ requesters.
// Define UART_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int GAP_TIMEOUT = DEFAULT_GAP_TIMEOUT
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [NUM_REQ-1:0]   i_Req,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]   i_Req_Last,
    output logic [NUM_REQ-1:0]   o_Req_Ack,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic                 o_Busy,
    output logic                 o_Timeout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = $clog2(GAP_TIMEOUT);

    arb_state_t         state;
    logic [GAP_W-1:0]   gap_cnt;
    logic               last_q;
    logic [NUM_REQ-1:0] pick;
    logic [PTR_W-1:0]   sel_ptr;
    logic               owner_req;
    logic               owner_last;
    logic [7:0]         owner_byte;
    logic               timeout_hit;

    // The serializer is paced purely by its done pulse.
    logic unused_tx_active;
    assign unused_tx_active = i_Tx_Active;

    assign owner_req   = |(i_Req & o_Grant);
    assign timeout_hit = (gap_cnt == GAP_W'(GAP_TIMEOUT - 1));
    assign o_Busy      = (state != S_IDLE);

    always_comb begin
        owner_byte = '0;
        owner_last = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (o_Grant[k]) begin
                owner_byte |= i_Req_Byte[8*k +: 8];
                owner_last |= i_Req_Last[k];
            end
        end
    end

`ifdef UART_ARB_FIXED_PRIORITY_EN
    assign sel_ptr = '0;
`else
    logic [PTR_W-1:0] ptr;
    logic [2:0]       owner_idx;
    logic             release_grant;

    assign owner_idx = onehot_to_idx(MAX_REQ'(o_Grant));
    assign release_grant = (state == S_GAP && last_q) ||
                           (state == S_HOLD && !owner_req && timeout_hit);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            ptr <= '0;
        end else if (release_grant) begin
            ptr <= PTR_W'((int'(owner_idx) + 1) % NUM_REQ);
        end
    end

    assign sel_ptr = ptr;
`endif

    uart_rr_select #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_select (
        .req   (i_Req),
        .ptr   (sel_ptr),
        .grant (pick)
    );

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state     <= S_IDLE;
            o_Grant   <= '0;
            o_Req_Ack <= '0;
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= '0;
            o_Timeout <= 1'b0;
            gap_cnt   <= '0;
            last_q    <= 1'b0;
        end else begin
            o_Req_Ack <= '0;
            o_Tx_DV   <= 1'b0;
            o_Timeout <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (|i_Req) state <= S_ARB;
                end
                S_ARB: begin
                    o_Grant <= pick;
                    state   <= (|pick) ? S_LOAD : S_IDLE;
                end
                S_LOAD: begin
                    if (owner_req) begin
                        o_Tx_DV   <= 1'b1;
                        o_Tx_Byte <= owner_byte;
                        o_Req_Ack <= o_Grant;
                        last_q    <= owner_last;
                        state     <= S_WAIT;
                    end else begin
                        state <= S_HOLD;
                    end
                end
                S_WAIT: begin
                    if (i_Tx_Done) state <= S_GAP;
                end
                S_GAP: begin
                    if (last_q) begin
                        o_Grant <= '0;
                        state   <= S_IDLE;
                    end else begin
                        state <= S_LOAD;
                    end
                end
                S_HOLD: begin
                    if (owner_req) begin
                        gap_cnt <= '0;
                        state   <= S_LOAD;
                    end else if (timeout_hit) begin
                        gap_cnt   <= '0;
                        o_Timeout <= 1'b1;
                        o_Grant   <= '0;
                        state     <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx and serial receiver.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 2;
    localparam int GAP_TO  = 8;
    localparam int CPB     = 4;
    localparam int LIMIT   = 3000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NUM_REQ-1:0]   req      = '0;
    logic [NUM_REQ-1:0]   req_last = '0;
    logic [8*NUM_REQ-1:0] req_byte = '0;
    logic [NUM_REQ-1:0]   ack, grant;
    logic       tx_dv, busy, timeout;
    logic [7:0] tx_byte;

    logic       tx_active = 1'b0;
    logic       tx_done   = 1'b0;
    logic       serial    = 1'b1;
    logic [9:0] frame     = '1;
    int         bit_i     = 0;
    int         clk_i     = 0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         r;
        logic [7:0] b;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .GAP_TIMEOUT (GAP_TO)
    ) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Req       (req),
        .i_Req_Byte  (req_byte),
        .i_Req_Last  (req_last),
        .o_Req_Ack   (ack),
        .o_Grant     (grant),
        .o_Tx_DV     (tx_dv),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done),
        .o_Busy      (busy),
        .o_Timeout   (timeout)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] b);
        exp_q.push_back('{r, b});
        rx_q.push_back(b);
    endtask

    // uart_tx stand-in: not reset by the arbiter's reset, keeps shifting.
    always @(posedge clk) begin
        tx_done <= 1'b0;
        if (!tx_active) begin
            serial <= 1'b1;
            if (tx_dv) begin
                tx_active <= 1'b1;
                frame     <= {1'b1, tx_byte, 1'b0};
                bit_i     <= 0;
                clk_i     <= 0;
                serial    <= 1'b0;
            end
        end else if (clk_i == CPB - 1) begin
            clk_i <= 0;
            if (bit_i == 9) begin
                tx_active <= 1'b0;
                tx_done   <= 1'b1;
                serial    <= 1'b1;
            end else begin
                bit_i  <= bit_i + 1;
                serial <= frame[bit_i+1];
            end
        end else begin
            clk_i <= clk_i + 1;
        end
    end

    // Launch monitor: every DV must match the next expected byte and owner.
    always @(negedge clk) begin
        exp_t e;
        if (tx_dv) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dv_unexpected: got byte %0h, nothing queued", tx_byte);
            end else begin
                e = exp_q.pop_front();
                check("dv_byte", tx_byte, e.b);
                check("dv_grant", grant, 1 << e.r);
                check("dv_ack", ack, 1 << e.r);
                check("dv_busy", busy, 1);
            end
        end else begin
            check("ack_without_dv", ack, 0);
        end
    end

    // Serial receiver: decodes the line mid-bit.
    initial begin
        logic [7:0] rb;
        logic [7:0] want;
        forever begin
            @(negedge serial);
            repeat (CPB / 2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                rb[i] = serial;
            end
            repeat (CPB) @(posedge clk);
            if (rx_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_unexpected: got %0h, nothing queued", rb);
            end else begin
                want = rx_q.pop_front();
                check("rx_byte", rb, want);
            end
        end
    end

    task automatic send_byte(input int r, input logic [7:0] b,
                             input logic last, output int lat);
        req_byte[8*r +: 8] = b;
        req_last[r] = last;
        req[r] = 1'b1;
        lat = 0;
        while (lat < LIMIT) begin
            @(negedge clk);
            lat++;
            if (ack[r]) break;
        end
        check($sformatf("ack_seen_r%0d", r), ack[r], 1);
        req[r] = 1'b0;
        req_last[r] = 1'b0;
    endtask

    task automatic send_pkt(input int r, input logic [7:0] b0,
                            input logic [7:0] b1);
        int lat;
        send_byte(r, b0, 1'b0, lat);
        send_byte(r, b1, 1'b1, lat);
    endtask

    task automatic wait_quiet(input string name);
        int n = 0;
        while ((busy || tx_active || exp_q.size() != 0 || rx_q.size() != 0)
               && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check(name, n < LIMIT, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, lat0, lat1, n;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_grant", grant, 0);
        check("rst_dv", tx_dv, 0);
        check("rst_byte", tx_byte, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single two-byte packet
        push(0, 8'h55);
        push(0, 8'hA3);
        send_byte(0, 8'h55, 1'b0, lat);
        check("first_latency", lat, 3);
        send_byte(0, 8'hA3, 1'b1, lat);
        wait_quiet("single_done");
        check("single_grant_free", grant, 0);

        // Two requesters, two packets each, starting from reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`ifdef UART_ARB_FIXED_PRIORITY_EN
        push(0, 8'h11); push(0, 8'h12); push(0, 8'h21); push(0, 8'h22);
        push(1, 8'h31); push(1, 8'h32); push(1, 8'h41); push(1, 8'h42);
`else
        push(0, 8'h11); push(0, 8'h12); push(1, 8'h31); push(1, 8'h32);
        push(0, 8'h21); push(0, 8'h22); push(1, 8'h41); push(1, 8'h42);
`endif
        fork
            begin
                send_pkt(0, 8'h11, 8'h12);
                send_pkt(0, 8'h21, 8'h22);
            end
            begin
                send_pkt(1, 8'h31, 8'h32);
                send_pkt(1, 8'h41, 8'h42);
            end
        join
        wait_quiet("arb_done");

        // Non-owner request arriving mid-packet must wait
        push(0, 8'h51);
        push(0, 8'h52);
        push(1, 8'h61);
        fork
            send_pkt(0, 8'h51, 8'h52);
            begin
                repeat (10) @(negedge clk);
                send_byte(1, 8'h61, 1'b1, lat1);
                check("stall_waited", lat1 > 40, 1);
            end
        join
        wait_quiet("stall_done");

        // Gap timeout: req1 stalls mid-packet, pending req0 served next
        push(1, 8'h10);
        push(0, 8'h77);
        send_byte(1, 8'h10, 1'b0, lat1);
        fork
            send_byte(0, 8'h77, 1'b1, lat0);
            begin
                n = 0;
                while (!tx_done && n < LIMIT) begin
                    @(negedge clk);
                    n++;
                end
                check("gap_done_seen", tx_done, 1);
                n = 0;
                while (!timeout && n < LIMIT) begin
                    @(negedge clk);
                    n++;
                end
                check("timeout_delay", n, 11);
                check("timeout_grant_free", grant, 0);
                @(negedge clk);
                check("timeout_one_cycle", timeout, 0);
            end
        join
        wait_quiet("timeout_done");

        // Asynchronous reset while waiting on the serializer
        push(0, 8'h3C);
        send_byte(0, 8'h3C, 1'b0, lat);
        repeat (5) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_byte", tx_byte, 8'h3C);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outputs",
              {24'd0, ack, grant, tx_dv, busy, timeout, 1'b0}, 0);
        check("async_rst_byte", tx_byte, 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (tx_active && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("serializer_drained", tx_active, 0);
        @(negedge clk);
        check("done_ignored_idle", busy, 0);
        push(0, 8'h81);
        push(1, 8'h91);
        fork
            send_byte(0, 8'h81, 1'b1, lat0);
            send_byte(1, 8'h91, 1'b1, lat1);
        join
        check("post_rst_latency", lat0, 3);
        wait_quiet("post_rst_done");

        check("exp_q_empty", exp_q.size(), 0);
        check("rx_q_empty", rx_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer between NUM_REQ byte-stream requesters, e.g. the I2C-to-UART data path and a status/echo source.
- Grants the transmitter per packet, not per byte, so frames from different requesters never interleave.
- Drives the serializer's data-valid/byte inputs and paces each byte on its done pulse.
- Sits between the bridge's request sources and uart_tx.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- GAP_TIMEOUT, 1024, clocks the granted requester may idle mid-packet before its grant is revoked (>=2).

Ports:
- i_Clock  input  1  system clock; all logic on posedge.
- i_Reset  input  1  asynchronous active-high reset.
- i_Req  input  NUM_REQ  per-requester byte valid.
- i_Req_Byte  input  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k].
- i_Req_Last  input  NUM_REQ  qualifies i_Req: this byte ends the packet.
- o_Req_Ack  output  NUM_REQ  one-cycle pulse: the presented byte was taken.
- o_Grant  output  NUM_REQ  one-hot owner of the transmitter; 0 when free.
- o_Tx_DV  output  1  one-cycle start pulse to uart_tx.
- o_Tx_Byte  output  8  byte to uart_tx; held stable from the DV cycle until i_Tx_Done.
- i_Tx_Active  input  1  from uart_tx.
- i_Tx_Done  input  1  from uart_tx; end-of-frame pulse.
- o_Busy  output  1  high in every state except S_IDLE.
- o_Timeout  output  1  one-cycle pulse when a grant is revoked by the gap timer.

Behaviour:
- Reset (async, i_Reset=1):
  - Outputs: o_Req_Ack=0, o_Grant=0, o_Tx_DV=0, o_Tx_Byte=0, o_Busy=0, o_Timeout=0.
  - Internal: state=S_IDLE, round-robin pointer=0, gap counter=0.
  - Reset mid-frame abandons the packet; the arbiter does not re-synchronise with a serializer still shifting.
- Requester handshake:
  - A requester holds i_Req, i_Req_Byte and i_Req_Last stable until its o_Req_Ack.
  - The ack pulses only in the cycle the byte is launched.
- States:
  - S_IDLE: if any i_Req, go to S_ARB. The arbitration decision uses the next cycle's sample.
  - S_ARB: pick the winner by round-robin, searching from pointer to NUM_REQ-1 and then wrapping. Register it as one-hot o_Grant; go to S_LOAD. If the request dropped, return to S_IDLE with o_Grant=0.
  - S_LOAD:
    - If i_Req[owner]=1: o_Tx_DV=1 for exactly one cycle, o_Tx_Byte registered, o_Req_Ack[owner]=1, latch i_Req_Last. Go to S_WAIT.
    - If i_Req[owner]=0: go to S_HOLD.
  - S_WAIT: wait for i_Tx_Done=1, then go to S_GAP. o_Tx_DV stays 0.
  - S_GAP:
    - One cycle so uart_tx returns to idle.
    - If the latched last flag is set: o_Grant=0, pointer=(owner+1) mod NUM_REQ, go to S_IDLE.
    - Otherwise go to S_LOAD.
  - S_HOLD:
    - Increment the gap counter each cycle; on i_Req[owner], clear it and go to S_LOAD.
    - When the counter reaches GAP_TIMEOUT-1: pulse o_Timeout, release the grant, advance the pointer, go to S_IDLE.
- Latency:
  - From i_Req rising in S_IDLE to o_Tx_DV: 3 cycles (IDLE, ARB, LOAD).
  - Back-to-back bytes within a packet: DV-to-DV = (uart_tx frame time) + 2 cycles.
- Boundaries:
  - Simultaneous requests: exactly one grant.
  - Pointer wraps NUM_REQ-1 -> 0.
  - A non-owner request during a packet waits; it is never acked.
  - i_Req_Last on the first byte gives a single-byte packet.
  - i_Tx_Done arriving in any state other than S_WAIT is ignored.
- Counter widths: gap counter is $clog2(GAP_TIMEOUT) bits; pointer is $clog2(NUM_REQ) bits.

Optional Feature:
- Macro UART_ARB_FIXED_PRIORITY_EN.
- Defined:
  - S_ARB picks the lowest-index requesting input.
  - The pointer is not instantiated.
  - Timeout still applies.
- Undefined: round-robin as above.

Decomposition:
- Package uart_arb_pkg: state encoding constants (S_IDLE, S_ARB, S_LOAD, S_WAIT, S_GAP, S_HOLD, 3-bit), a function for the one-hot-to-index conversion, and the default GAP_TIMEOUT.
- One natural sub-module, uart_rr_select: combinational round-robin/priority picker taking the request vector and pointer and returning a one-hot winner. Tested standalone.

Test Plan:
- Single packet:
  - Stimulus: req0 sends 0x55, 0xA3 (last), CLKS_PER_BIT=4.
  - Response: o_Tx_DV pulses 3 cycles after req; serial line shows 0x55 then 0xA3; o_Grant=01 throughout, 00 after the second S_GAP.
- Round-robin:
  - Stimulus: req0 and req1 both hold 2-byte packets from reset.
  - Response: req0's packet goes first and complete, then req1's, no interleave. Repeat: order alternates 0,1,0,1.
- Fixed priority (with UART_ARB_FIXED_PRIORITY_EN):
  - Stimulus: same traffic as the round-robin test.
  - Response: req0 always wins while it keeps requesting.
- Gap timeout:
  - Stimulus: GAP_TIMEOUT=8; req1 sends 0x10 (not last), then drops i_Req.
  - Response: o_Timeout pulses 8 cycles after entering S_HOLD; grant released; a pending req0 is served next.
- Reset mid-frame:
  - Stimulus: assert i_Reset during S_WAIT.
  - Response: all outputs 0 immediately (async); pointer=0; the next request is served normally after uart_tx finishes.
- Non-owner stall:
  - Stimulus: req1 asserts while req0 is mid-packet.
  - Response: o_Req_Ack[1] stays 0 until req0's last byte completes.
